// File: rtl/ff_t_checker.sv
// ff_t_checker: observes a T flip-flop over a LEN-cycle window against a toggle model and reports results
module ff_t_checker #(
  parameter int LEN = 16,
  parameter int CW  = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           t_i,
  input  logic           q_i,
  input  logic           qb_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [CW-1:0]  err_count_o,
  output logic [CW-1:0]  first_err_idx_o,
  output logic [LEN-1:0] seq_t_o,
  output logic [LEN-1:0] seq_q_o
);
  // Window index is sized for LEN itself so the window length never depends on CW.
  localparam int IW = $clog2(LEN + 1);
  typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           exp_q, exp_d, done_q, done_d, pass_q, pass_d, fail;
  logic [CW-1:0]  err_q, err_d, first_q, first_d;
  logic [LEN-1:0] seq_t_q, seq_t_d, seq_q_q, seq_q_d;
  // Next-state and result update; a cycle fails on model mismatch or a broken complement, counted once.
  always_comb begin
    fail    = (q_i != exp_q) || (qb_i == q_i);
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    first_d = first_q;
    seq_t_d = seq_t_q;
    seq_q_d = seq_q_q;
    unique case (state_q)
      IDLE: state_d = start_i ? ARM : IDLE;
      ARM: begin
        exp_d   = q_i;
        err_d   = '0;
        first_d = CW'(LEN);
        seq_t_d = '0;
        seq_q_d = '0;
        idx_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        seq_t_d = seq_t_q | (LEN'(t_i) << idx_q);
        seq_q_d = seq_q_q | (LEN'(q_i) << idx_q);
        exp_d   = exp_q ^ t_i;
        err_d   = (fail && err_q != '1) ? err_q + CW'(1) : err_q;
        first_d = (fail && err_q == '0) ? CW'(idx_q) : first_q;
        idx_d   = idx_q + IW'(1);
        state_d = (idx_q == IW'(LEN - 1)) ? DONE : CHECK;
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and result registers; reset discards any partial window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      seq_t_q <= '0;
      seq_q_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      seq_t_q <= seq_t_d;
      seq_q_q <= seq_q_d;
    end
  end
  assign busy_o          = (state_q == ARM) || (state_q == CHECK);
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_q;
  assign seq_t_o         = seq_t_q;
  assign seq_q_o         = seq_q_q;
endmodule

// File: doc/ff_t_checker.md
# ff_t_checker

Self-checking response monitor for T flip-flops: the checking end of the toggle-stimulus interface. It observes a flip-flop's `t`, `q`, `qb` for a window of `LEN` clock cycles, runs its own toggle reference model, and reports pass/fail, an error count, the index of the first failing cycle, and the captured `t`/`q` traces. It sits next to a T flip-flop under test, either in silicon self-test or on a bench, and replaces manual inspection of printed waveforms.

## Interface
- `LEN`, default 16: check window length in cycles (≥ 1).
- `CW`, default 5: width of the count and index outputs; must satisfy 2^CW > LEN.
- `clk`  in  1: rising-edge clock, shared with the flip-flop under test.
- `rst`  in  1: reset; one clock, asynchronous, active-low.
- `start`  in  1: arm request, sampled in IDLE only.
- `t`  in  1: toggle input driven to the flip-flop under test.
- `q`  in  1: flip-flop output.
- `qb`  in  1: flip-flop complementary output.
- `busy`  out  1: high in ARM and CHECK.
- `done`  out  1: one-cycle pulse when results become valid.
- `pass`  out  1: 1 if zero errors in the last completed window.
- `err_count`  out  CW: failing cycles in the window; saturates at 2^CW−1.
- `first_err_idx`  out  CW: index (0..LEN−1) of the first failing cycle; `LEN` if none.
- `seq_t`  out  LEN: captured `t`; bit k is the value at check cycle k.
- `seq_q`  out  LEN: captured `q`; bit k is the value at check cycle k.

## Operation
- FSM states: IDLE → ARM → CHECK → DONE → IDLE.
- IDLE:
  - `start`=1 at an edge → ARM.
  - Otherwise stay in IDLE; results from the previous window are held.
- ARM, one cycle:
  - Sample `q` into the model register `exp`.
  - Clear the error counter, set the first-error register to `LEN`, and clear `seq_t` and `seq_q`.
  - → CHECK.
- CHECK, exactly `LEN` cycles, index k = 0..LEN−1. At each edge:
  - Capture `t` and `q` into bit k.
  - Cycle k fails if `q`≠`exp` or `qb`≠~`q`. Both mismatching in one cycle counts as one error.
  - On a failure, increment the error counter (saturating). If this is the first failure, record k.
  - Update the model: `exp` ← `exp` ^ `t`, using the `t` sampled in cycle k. This gives the expectation for cycle k+1.
  - After k = LEN−1 → DONE.
- DONE, one cycle:
  - `done`=1.
  - `pass` ← (error counter == 0).
  - → IDLE.
- `start` in ARM, CHECK or DONE is ignored; it is not queued.
- Result outputs (`pass`, `err_count`, `first_err_idx`, `seq_t`, `seq_q`) are registered and change only in ARM/CHECK/DONE. Consumers read them only when `done`=1 or afterwards.
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0, `seq_t`=0, `seq_q`=0, `exp`=0.
- `rst` low in any state clears everything immediately; no partial result is reported.

## Timing
- Let edge 0 be the edge where `start`=1 is sampled in IDLE.
  - Edge 1: ARM; `busy` rises after edge 0.
  - Edges 2..LEN+1: CHECK samples, with k = edge − 2.
  - Edge LEN+2: DONE; `done`=1, `busy`=0.
- Latency from `start` to `done` is LEN+2 cycles. Back-to-back windows are possible with `start` asserted in the IDLE cycle right after DONE.
- Inputs are sampled on the same edge that clocks the flip-flop under test. The `q` sampled at k therefore reflects the `t` presented before edge k−1, which matches the model update rule.
- `first_err_idx` and the error count update on the edge of the failing sample. They are visible from the next cycle.

## Test plan
- Reset:
  - Drive `rst`=0 mid-CHECK at k=8 → all outputs go to reset values asynchronously and the FSM is IDLE.
  - After release, a new `start` runs a full 16-cycle window.
- Hold, LEN=16: `t`=0 for all cycles, `q`=1, `qb`=0 → `done` at start+18, `pass`=1, `err_count`=0, `first_err_idx`=16, `seq_t`=0x0000, `seq_q`=0xFFFF.
- Toggle, LEN=16: correct flip-flop, `t`=1 throughout, `q` starts at 0 → `pass`=1, `seq_q`=0xAAAA (bit0=0).
- Stuck output: `t`=1 throughout, `q` stuck at 0, `qb`=1 → `err_count`=8, `first_err_idx`=1, `pass`=0.
  - With `CW`=3, same stimulus → `err_count`=7 (saturated).
- Complement fault: correct `q`, but `qb`=`q` only at k=5 → `err_count`=1, `first_err_idx`=5, `pass`=0.
- Ignored start: pulse `start` at k=3 and in the DONE cycle → exactly one `done` pulse.
  - Results are unchanged.
  - `busy` stays 0 after DONE until a new IDLE-cycle `start` arrives.
